// File: rtl/tea_pkg.sv
// -----------------------------------------------------------------------------
// tea_pkg -- shared definitions for the TEA encryptor and decryptor cores.
//
// Contents:
//   WORD_W / BLOCK_W / KEY_W : datapath widths (32 / 64 / 128 bits)
//   TEA_DELTA                : default key-schedule constant
//   word_t                   : one 32-bit TEA half-block word
//   tea_state_t              : IDLE / RUN / DONE control states
//   tea_mix()                : the Feistel mixing term shared by both directions
// -----------------------------------------------------------------------------
package tea_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 128;

    localparam logic [WORD_W-1:0] TEA_DELTA = 32'h9E37_79B9;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_t;

    // ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb), all modulo 2^32,
    // logical shifts with zero fill.
    function automatic word_t tea_mix(word_t v, word_t sum, word_t ka, word_t kb);
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_decrypt_core_if.sv
// -----------------------------------------------------------------------------
// tea_decrypt_core_if -- block-level handshake bundle for tea_decrypt_core.
//
// Signals:
//   in_valid / in_ready : input handshake, ciphertext + key offered together
//   ciphertext [63:0]   : {v0, v1}
//   key [127:0]         : {k0, k1, k2, k3}
//   out_valid/out_ready : output handshake
//   plaintext [63:0]    : {v0, v1}
//   busy                : core is not idle
// Modports: master = producer/consumer side, slave = the core.
// -----------------------------------------------------------------------------
interface tea_decrypt_core_if;
    import tea_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] ciphertext;
    logic [KEY_W-1:0]   key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] plaintext;
    logic               busy;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );

endinterface

// File: rtl/tea_dec_round.sv
// -----------------------------------------------------------------------------
// tea_dec_round -- one combinational TEA decryption round.
//
// Ports:
//   v0, v1   in  : current half-blocks
//   sum      in  : round sum for this round
//   key      in  : {k0, k1, k2, k3}
//   v0_next  out : v0 after the round
//   v1_next  out : v1 after the round
// v1 is updated first; the v0 update uses the new v1.
// -----------------------------------------------------------------------------
module tea_dec_round
    import tea_pkg::*;
(
    input  word_t            v0,
    input  word_t            v1,
    input  word_t            sum,
    input  logic [KEY_W-1:0] key,
    output word_t            v0_next,
    output word_t            v1_next
);

    word_t k0, k1, k2, k3;

    assign k0 = key[127:96];
    assign k1 = key[95:64];
    assign k2 = key[63:32];
    assign k3 = key[31:0];

    assign v1_next = v1 - tea_mix(v0, sum, k2, k3);
    assign v0_next = v0 - tea_mix(v1_next, sum, k0, k1);

endmodule

// File: rtl/tea_decrypt_core.sv
// -----------------------------------------------------------------------------
// tea_decrypt_core -- iterative TEA block decryptor, one round per clock.
//
// Parameters:
//   DELTA  : key-schedule constant, must match the encryptor
//   ROUNDS : number of rounds, 1..255
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   abort  : (only with TEA_DEC_ABORT_EN) drop the block in flight
//   bus    : tea_decrypt_core_if.slave handshake bundle
// Optional feature: define TEA_DEC_ABORT_EN to add the abort input.
//
// Timing: accept on edge A, out_valid rises after edge A+ROUNDS, plaintext
// held until out_ready; in_ready returns the cycle after the handshake.
// -----------------------------------------------------------------------------
module tea_decrypt_core
    import tea_pkg::*;
#(
    parameter logic [WORD_W-1:0] DELTA  = TEA_DELTA,
    parameter int                ROUNDS = 32
) (
    input  logic clk,
    input  logic rst_n,
`ifdef TEA_DEC_ABORT_EN
    input  logic abort,
`endif
    tea_decrypt_core_if.slave bus
);

    // Starting sum for decryption is DELTA*ROUNDS wrapped to 32 bits.
    localparam logic [2*WORD_W-1:0] SUM_FULL = 64'(DELTA) * 64'(ROUNDS);
    localparam word_t               SUM_INIT = SUM_FULL[WORD_W-1:0];
    localparam logic [7:0]          CNT_INIT = 8'(ROUNDS);

    tea_state_t       state_q, state_d;
    word_t            v0_q, v1_q, sum_q;
    word_t            v0_next, v1_next;
    logic [KEY_W-1:0] key_q;
    logic [7:0]       cnt_q;
    logic             rst_done_q;
    logic             accept;
    logic             abort_w;
    logic             out_valid_w;

`ifdef TEA_DEC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Abort masks out_valid so no handshake can complete in the same cycle.
    assign out_valid_w = (state_q == DONE) && !abort_w;
    // rst_done_q keeps in_ready low while reset is held and until the
    // first edge after release.
    assign accept      = bus.in_valid && (state_q == IDLE) && rst_done_q;

    tea_dec_round u_round (
        .v0      (v0_q),
        .v1      (v1_q),
        .sum     (sum_q),
        .key     (key_q),
        .v0_next (v0_next),
        .v1_next (v1_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: state_d gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (abort_w)            state_d = IDLE;
                else if (cnt_q == 8'd1) state_d = DONE;
            end
            DONE: begin
                if (abort_w)            state_d = IDLE;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && rst_done_q;
        bus.out_valid = out_valid_w;
        bus.busy      = (state_q != IDLE);
        bus.plaintext = {v0_q, v1_q};
    end

    // Datapath: block, key, sum and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q  <= '0;
            v1_q  <= '0;
            sum_q <= '0;
            key_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            v0_q  <= bus.ciphertext[63:32];
            v1_q  <= bus.ciphertext[31:0];
            key_q <= bus.key;
            sum_q <= SUM_INIT;
            cnt_q <= CNT_INIT;
        end else if (state_q == RUN) begin
            v0_q  <= v0_next;
            v1_q  <= v1_next;
            sum_q <= sum_q - DELTA;
            cnt_q <= cnt_q - 8'd1;
        end
    end

endmodule
